// File: rtl/uart_rx_frame.sv
// Oversampling UART frame receiver: start/LSB-first data/optional parity/stop, mid-bit sampling.
// Define RX_MAJORITY_VOTE_EN to decide each bit by a 3-sample majority around the bit centre.
module uart_rx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid,
  output logic                  Par_err,
  output logic                  Stop_err
);

  localparam int CW   = $clog2(OVERSAMPLE);
  localparam int BW   = $clog2(DATA_WIDTH);
  localparam int HALF = OVERSAMPLE / 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_d;
  logic                  sync1, rx_s;
  logic [CW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  armed, par_en_q, par_typ_q, par_bad;
  logic                  tick_last, start_det, bit_val;

  assign tick_last = (edge_cnt == CW'(OVERSAMPLE - 1));
  assign start_det = (state == IDLE) && armed && !rx_s;

`ifdef RX_MAJORITY_VOTE_EN
  logic [2:0] smp;
  logic [2:0] vote;

  always_ff @(posedge clk or posedge RST) begin
    if (RST)
      smp <= 3'b111;
    else if (state != IDLE && edge_cnt >= CW'(HALF - 1) && edge_cnt <= CW'(HALF + 1))
      smp <= {smp[1:0], rx_s};
  end

  // With OVERSAMPLE = 4 the third sample tick is the decision tick itself.
  assign vote    = (HALF + 1 == OVERSAMPLE - 1) ? {smp[1:0], rx_s} : smp;
  assign bit_val = (vote[0] & vote[1]) | (vote[0] & vote[2]) | (vote[1] & vote[2]);
`else
  logic smp;

  always_ff @(posedge clk or posedge RST) begin
    if (RST)
      smp <= 1'b1;
    else if (state != IDLE && edge_cnt == CW'(HALF))
      smp <= rx_s;
  end

  assign bit_val = smp;
`endif

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_d;
  end

  // NOTE: every always_comb output gets its default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:   if (start_det) state_d = START;
      START:  if (tick_last) state_d = bit_val ? IDLE : DATA;
      DATA:   if (tick_last && bit_cnt == BW'(DATA_WIDTH - 1))
                state_d = par_en_q ? PARITY : STOP;
      PARITY: if (tick_last) state_d = STOP;
      STOP:   if (tick_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      armed      <= 1'b1;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad    <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
      Par_err    <= 1'b0;
      Stop_err   <= 1'b0;
    end else begin
      sync1      <= RX_IN;
      rx_s       <= sync1;
      Data_Valid <= 1'b0;
      Par_err    <= 1'b0;
      Stop_err   <= 1'b0;

      if (!armed && rx_s) armed <= 1'b1;

      if (state == IDLE) begin
        // The detection cycle counts as tick 0 of the start bit.
        edge_cnt <= start_det ? CW'(1) : '0;
        bit_cnt  <= '0;
        if (start_det) begin
          par_en_q  <= PAR_EN;
          par_typ_q <= PAR_TYP;
          par_bad   <= 1'b0;
        end
      end else begin
        edge_cnt <= tick_last ? '0 : edge_cnt + 1'b1;
      end

      if (tick_last) begin
        case (state)
          DATA: begin
            shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
            bit_cnt <= (bit_cnt == BW'(DATA_WIDTH - 1)) ? '0 : bit_cnt + 1'b1;
          end
          PARITY: par_bad <= (bit_val != (^shreg ^ par_typ_q));
          STOP: begin
            if (!bit_val) begin
              // Line held low (break) must go high before the next start is trusted.
              Stop_err <= 1'b1;
              Par_err  <= par_bad;
              armed    <= 1'b0;
            end else if (par_bad) begin
              Par_err <= 1'b1;
            end else begin
              Data_Valid <= 1'b1;
              P_DATA     <= shreg;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: line-history reference decoder plus directed frames.
module tb_uart_rx_frame;

  localparam int OS   = 8;
  localparam int HMAX = 8192;

  logic       clk = 1'b0;
  logic       RST, RX_IN, PAR_EN, PAR_TYP;
  logic [7:0] P_DATA;
  logic       Data_Valid, Par_err, Stop_err;

  always #5 clk = ~clk;

  uart_rx_frame #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
    .clk(clk), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .Data_Valid(Data_Valid), .Par_err(Par_err), .Stop_err(Stop_err)
  );

  int n_vec = 0, n_fail = 0;
  int edges = 0;
  logic line_h [0:HMAX-1];
  logic pe_h   [0:HMAX-1];
  logic pt_h   [0:HMAX-1];

  // Line value seen by each clock edge, indexed by edge number.
  always @(posedge clk) begin
    if (edges < HMAX) begin
      line_h[edges] = RX_IN;
      pe_h[edges]   = PAR_EN;
      pt_h[edges]   = PAR_TYP;
    end
    edges = edges + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic bitv(input int idx);
`ifdef RX_MAJORITY_VOTE_EN
    int s;
    s = int'(line_h[idx-1]) + int'(line_h[idx]) + int'(line_h[idx+1]);
    return (s >= 2);
`else
    return line_h[idx];
`endif
  endfunction

  // Reference decoder state
  int         m_search = 0, m_e0 = 0;
  bit         in_frame = 0, start_ok = 0, need_high = 0;
  int         ev_cyc = -1, ev_kind = 0;
  logic [7:0] ev_data = '0, exp_pdata = '0;
  int         dv_at = -1, pe_at = -1, se_at = -1, dv_cnt = 0;

  task automatic model_step(input int c);
    int nb, ones;
    logic [7:0] d;
    logic stop_b, pb, par_ok;
    if (in_frame && !start_ok && c >= m_e0 + OS) begin
      if (bitv(m_e0 + OS/2)) begin
        in_frame = 0;
        m_search = m_e0 + OS;
      end else start_ok = 1;
    end
    if (in_frame && start_ok) begin
      nb = 10 + int'(pe_h[m_e0+2]);
      if (c >= m_e0 + OS*nb) begin
        for (int i = 0; i < 8; i++) d[i] = bitv(m_e0 + OS*(i+1) + OS/2);
        stop_b = bitv(m_e0 + OS*(nb-1) + OS/2);
        par_ok = 1'b1;
        if (nb == 11) begin
          pb     = bitv(m_e0 + OS*9 + OS/2);
          ones   = $countones(d) + int'(pb);
          par_ok = ((ones % 2) == int'(pt_h[m_e0+2]));
        end
        if (!stop_b) begin
          ev_kind   = par_ok ? 2 : 3;
          need_high = 1;
        end else ev_kind = par_ok ? 0 : 1;
        ev_cyc   = m_e0 + OS*nb + 1;
        ev_data  = d;
        in_frame = 0;
        m_search = m_e0 + OS*nb;
      end
    end
    while (!in_frame && m_search <= c) begin
      if (need_high) begin
        if (line_h[m_search]) need_high = 0;
        m_search++;
      end else if (!line_h[m_search]) begin
        in_frame = 1;
        start_ok = 0;
        m_e0     = m_search;
      end else m_search++;
    end
  endtask

  // Per-cycle compare of every output against the reference decoder
  initial begin
    int c;
    logic e_dv, e_pe, e_se;
    forever begin
      @(posedge clk);
      #2;
      c = edges - 1;
      if (RST) begin
        in_frame  = 0;
        need_high = 0;
        ev_cyc    = -1;
        exp_pdata = '0;
        m_search  = edges;
      end else model_step(c);
      e_dv = (ev_cyc == c) && (ev_kind == 0);
      e_pe = (ev_cyc == c) && (ev_kind == 1 || ev_kind == 3);
      e_se = (ev_cyc == c) && (ev_kind >= 2);
      if (e_dv) exp_pdata = ev_data;
      check("cycle_outputs", {20'd0, P_DATA, 1'b0, Data_Valid, Par_err, Stop_err},
            {20'd0, exp_pdata, 1'b0, e_dv, e_pe, e_se});
      if (Data_Valid) begin dv_at = c; dv_cnt++; end
      if (Par_err)  pe_at = c;
      if (Stop_err) se_at = c;
    end
  end

  task automatic send(input logic [7:0] d, input bit pe, input bit pb, input bit stop,
                      input int glitch, input int ncyc, output int e0);
    logic [10:0] fr;
    int nb;
    nb = 10 + int'(pe);
    fr = '1;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[i+1] = d[i];
    if (pe) fr[9] = pb;
    fr[nb-1] = stop;
    e0 = -1;
    for (int k = 0; k < nb*OS; k++) begin
      if (ncyc >= 0 && k >= ncyc) break;
      @(negedge clk);
      if (k == 0) e0 = edges;
      RX_IN = (k == glitch) ? ~fr[k/OS] : fr[k/OS];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(negedge clk); RX_IN = 1'b1; end
  endtask

  task automatic hold_low(input int n);
    repeat (n) begin @(negedge clk); RX_IN = 1'b0; end
  endtask

  task automatic clear_marks();
    dv_at = -1; pe_at = -1; se_at = -1;
  endtask

  initial begin
    int e0, e0b, cnt0;
    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pdata", P_DATA, 0);
    check("reset_strobes", {Data_Valid, Par_err, Stop_err}, 0);
    RST = 1'b0;
    idle(4);

    // Plain frame, no parity: strobe 81 edges after E0
    clear_marks();
    send(8'hA5, 0, 0, 1, -1, -1, e0);
    idle(4);
    check("a5_latency", dv_at - e0, 81);
    check("a5_data", P_DATA, 8'hA5);
    check("a5_no_err", {pe_at < 0, se_at < 0}, 2'b11);

    // Even parity, correct then wrong parity bit
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    clear_marks();
    send(8'h3C, 1, 0, 1, -1, -1, e0);
    idle(4);
    check("par_ok_latency", dv_at - e0, 89);
    check("par_ok_data", P_DATA, 8'h3C);
    clear_marks();
    send(8'h3C, 1, 1, 1, -1, -1, e0);
    idle(4);
    check("par_err_latency", pe_at - e0, 89);
    check("par_err_no_valid", {dv_at < 0, se_at < 0}, 2'b11);
    check("par_err_hold_data", P_DATA, 8'h3C);

    // Stop bit low, then break held low
    PAR_EN = 1'b0;
    clear_marks();
    send(8'h81, 0, 0, 0, -1, -1, e0);
    hold_low(4);
    check("stop_err_latency", se_at - e0, 81);
    check("stop_err_no_valid", {dv_at < 0, pe_at < 0}, 2'b11);
    check("stop_err_hold_data", P_DATA, 8'h3C);
    clear_marks();
    hold_low(40);
    check("break_quiet", {dv_at < 0, pe_at < 0, se_at < 0}, 3'b111);
    idle(1);
    send(8'h66, 0, 0, 1, -1, -1, e0);
    idle(4);
    check("rearm_latency", dv_at - e0, 81);
    check("rearm_data", P_DATA, 8'h66);

    // Short low pulse on idle line is rejected
    clear_marks();
    hold_low(2);
    idle(20);
    check("glitch_start_quiet", {dv_at < 0, pe_at < 0, se_at < 0}, 3'b111);
    send(8'h5A, 0, 0, 1, -1, -1, e0);
    idle(4);
    check("after_glitch_latency", dv_at - e0, 81);
    check("after_glitch_data", P_DATA, 8'h5A);

    // One-tick inversion at the centre of data bit 3
    send(8'hFF, 0, 0, 1, 4*OS + OS/2, -1, e0);
    idle(4);
`ifdef RX_MAJORITY_VOTE_EN
    check("centre_glitch_data", P_DATA, 8'hFF);
`else
    check("centre_glitch_data", P_DATA, 8'hF7);
`endif

    // Reset in the middle of data bit 4
    send(8'hC3, 0, 0, 1, -1, 5*OS + 3, e0);
    @(negedge clk);
    RST = 1'b1; RX_IN = 1'b1;
    @(posedge clk);
    #3;
    check("midframe_reset_pdata", P_DATA, 0);
    check("midframe_reset_strobes", {Data_Valid, Par_err, Stop_err}, 0);
    @(negedge clk);
    RST = 1'b0;
    idle(4);
    clear_marks();
    send(8'h12, 0, 0, 1, -1, -1, e0);
    idle(4);
    check("post_reset_latency", dv_at - e0, 81);
    check("post_reset_data", P_DATA, 8'h12);

    // Back-to-back frames with zero idle gap
    clear_marks();
    cnt0 = dv_cnt;
    send(8'h01, 0, 0, 1, -1, -1, e0);
    send(8'h02, 0, 0, 1, -1, -1, e0b);
    idle(4);
    check("b2b_count", dv_cnt - cnt0, 2);
    check("b2b_gap", e0b - e0, 80);
    check("b2b_latency", dv_at - e0b, 81);
    check("b2b_data", P_DATA, 8'h02);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Oversampling UART receiver FSM that recovers frames emitted by the team's UART transmitter (start bit 0, LSB-first data, optional parity, stop bit 1). It sits directly downstream of the TX line, synchronises the asynchronous serial input, samples each bit mid-period, deserialises the data and checks parity and stop bits. Valid bytes are handed to the register-file/control side with a one-cycle strobe.

## Interface
- DATA_WIDTH, 8, data bits per frame
- OVERSAMPLE, 8, clk cycles per serial bit; one of 4, 8, 16, 32
- clk  input  1  receiver clock, OVERSAMPLE × TX bit rate
- RST  input  1  asynchronous, active-high reset
- RX_IN  input  1  serial line, asynchronous to clk, idles high
- PAR_EN  input  1  frame contains a parity bit
- PAR_TYP  input  1  0 = even parity, 1 = odd parity
- P_DATA  output  DATA_WIDTH  last received valid data word
- Data_Valid  output  1  one-cycle strobe, P_DATA updated
- Par_err  output  1  one-cycle strobe, parity mismatch
- Stop_err  output  1  one-cycle strobe, stop bit sampled 0

## Operation
- RX_IN passes through a 2-flop synchroniser (rx_s); all logic uses rx_s only.
- States: IDLE, START, DATA, PARITY, STOP. Tick counter edge_cnt 0..OVERSAMPLE-1 per bit; bit counter 0..DATA_WIDTH-1.
- IDLE: if armed and rx_s = 0 → START, edge_cnt = 1 (detection cycle is tick 0). PAR_EN and PAR_TYP latched here; changes mid-frame ignored.
- Bit value: rx_s at tick OVERSAMPLE/2 (see Configuration); decided at tick OVERSAMPLE-1.
- START end: sampled 0 → DATA; sampled 1 → IDLE (glitch rejected, no strobes).
- DATA: bits shifted in LSB first; after DATA_WIDTH bits → PARITY if latched PAR_EN else STOP.
- PARITY: expected = XOR(data) for even, ~XOR(data) for odd; mismatch recorded.
- STOP end → IDLE and exactly one outcome: stop = 0 → Stop_err (Par_err also if mismatch); stop = 1 with parity mismatch → Par_err; otherwise Data_Valid and P_DATA loaded.
- P_DATA changes only with Data_Valid; holds value through errored frames.
- Break handling: after Stop_err, armed clears; re-arms after rx_s = 1 for one cycle. armed = 1 out of reset.
- Reset (any time, including mid-frame): state IDLE, counters 0, armed 1, P_DATA 0, Data_Valid 0, Par_err 0, Stop_err 0, synchroniser flops 1.

## Timing
- Frame length N = 2 + DATA_WIDTH + PAR_EN bits.
- Edge E0 = first clk edge sampling RX_IN low. Strobe (Data_Valid / Par_err / Stop_err) high for the single cycle following edge E(N·OVERSAMPLE+1); all strobes registered.
- Defaults: no parity → 81 edges; parity → 89 edges.
- New start bit accepted in the cycle immediately after return to IDLE (back-to-back frames, zero idle gap supported).
- Start detection to stop sample tolerates ±OVERSAMPLE/2−1 ticks of cumulative rate error.

## Configuration
- RX_MAJORITY_VOTE_EN defined: bit value = majority of rx_s at ticks OVERSAMPLE/2−1, OVERSAMPLE/2, OVERSAMPLE/2+1; a single-tick glitch at the sample point does not corrupt the bit.
- Not defined: single sample at tick OVERSAMPLE/2; three-sample register logic absent. Latency identical in both builds.

## Test plan
- Defaults, PAR_EN=0, send 0xA5 → Data_Valid 81 edges after E0, P_DATA=0xA5, no error strobes.
- PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 → Data_Valid, P_DATA=0x3C; repeat with parity 1 → Par_err only, P_DATA stays 0x3C.
- Stop bit forced 0 on 0x81 → Stop_err, no Data_Valid; hold RX_IN low → no new frame until RX_IN high ≥1 cycle.
- 2-tick low pulse on idle line → START rejected, no strobes, next frame 0x5A received correctly.
- With RX_MAJORITY_VOTE_EN, 1-tick inverted glitch at tick 4 of data bit 3 of 0xFF → P_DATA=0xFF; without macro → 0xF7.
- Assert RST during data bit 4 → all outputs 0 next cycle; following full frame 0x12 received correctly; back-to-back 0x01, 0x02 both strobed.
